button_repeat_ctrl: RTL and testbench

//   Sequences the 0-9 button counter from two debounced switch levels.

---
 rtl/button_repeat_ctrl_pkg.sv | 34 +++
 rtl/button_repeat_ctrl_if.sv | 22 ++
 rtl/button_repeat_ctrl_repeat_timer.sv | 39 +++
 rtl/button_repeat_ctrl.sv | 177 +++++++++++++++++
 tb/tb_button_repeat_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/button_repeat_ctrl_pkg.sv
// Package for button_repeat_ctrl: FSM state codes, owner codes, 25 MHz timing defaults
// and a saturating helper for timer load values.
package button_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DELAY   = 2'd1,
      ST_REPEAT  = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_INC  = 2'b01,
      OWN_DEC  = 2'b10
   } owner_e;

   // Defaults for the 25 MHz Go Board clock.
   localparam int unsigned DEF_REPEAT_DELAY  = 12_500_000;  // 500 ms
   localparam int unsigned DEF_REPEAT_PERIOD = 2_500_000;   // 100 ms
   localparam int unsigned DEF_ACCEL_COUNT   = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Clamp a load value to what a WIDTH-bit timer can hold, so loads never wrap.
   function automatic int unsigned sat_load(input int unsigned val, input int unsigned width);
      longint unsigned lim;
      lim = (64'd1 << width) - 64'd1;
      return (64'(val) > lim) ? int'(lim) : val;
   endfunction

endpackage

// File: rtl/button_repeat_ctrl_if.sv
// Switch-level inputs and command outputs of button_repeat_ctrl.
// master: the side driving switch levels and consuming commands; slave: the controller.
interface button_repeat_ctrl_if;

   logic       i_Inc_Level;
   logic       i_Dec_Level;
   logic       o_Inc_Pulse;
   logic       o_Dec_Pulse;
   logic [1:0] o_Owner;
   logic       o_Repeating;

   modport master (
      output i_Inc_Level, i_Dec_Level,
      input  o_Inc_Pulse, o_Dec_Pulse, o_Owner, o_Repeating
   );

   modport slave (
      input  i_Inc_Level, i_Dec_Level,
      output o_Inc_Pulse, o_Dec_Pulse, o_Owner, o_Repeating
   );

endinterface

// File: rtl/button_repeat_ctrl_repeat_timer.sv
// repeat_timer: loadable down-counter used for the hold delay and repeat period.
// Load has priority over counting; the count holds at zero once reached.
module repeat_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic             i_Load,
   input  logic             i_En,
   input  logic [WIDTH-1:0] i_Load_Val,
   output logic             o_Zero
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Next count: load, else decrement while enabled and not yet at zero.
   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      cnt_d = cnt_q;
      if (i_Load) begin
         cnt_d = i_Load_Val;
      end else if (i_En && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   // Count register, cleared by reset.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
      if (i_Rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Zero flag straight off the register.
   always_comb begin
      o_Zero = (cnt_q == '0);
   end

endmodule

// File: rtl/button_repeat_ctrl.sv
// button_repeat_ctrl: turns debounced inc/dec switch levels into one-cycle counter
// commands with inc-wins arbitration, press-and-hold delay, and auto-repeat.
// Optional feature macro: BUTTON_REPEAT_ACCEL_EN (faster repeat after ACCEL_COUNT repeats).
module button_repeat_ctrl
   import button_ctrl_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int unsigned ACCEL_COUNT   = DEF_ACCEL_COUNT
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   button_repeat_ctrl_if.slave  bus
);

   // Reject parameter values the timing scheme cannot honour.
   if (REPEAT_DELAY < 2) begin : g_bad_delay
      $error("button_repeat_ctrl: REPEAT_DELAY must be >= 2");
   end
   if (REPEAT_PERIOD < 4) begin : g_bad_period
      $error("button_repeat_ctrl: REPEAT_PERIOD must be >= 4");
   end
   if (ACCEL_COUNT < 1) begin : g_bad_accel
      $error("button_repeat_ctrl: ACCEL_COUNT must be >= 1");
   end

   localparam int unsigned TW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));

   // Timer reload values: loading N-1 gives N cycles between successive pulses.
   localparam logic [TW-1:0] DELAY_LOAD  = TW'(sat_load(REPEAT_DELAY - 1, TW));
   localparam logic [TW-1:0] PERIOD_LOAD = TW'(sat_load(REPEAT_PERIOD - 1, TW));

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic            inc_pulse_q, inc_pulse_d;
   logic            dec_pulse_q, dec_pulse_d;
   logic            inc_prev_q, inc_prev_d;
   logic            dec_prev_q, dec_prev_d;

   logic            inc_edge, dec_edge;
   logic            owner_lvl, other_lvl;
   logic            fire, drop;
   logic            tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0]   tmr_load_val, rep_load_val;

   repeat_timer #(.WIDTH(TW)) u_timer (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Load     (tmr_load),
      .i_En       (tmr_en),
      .i_Load_Val (tmr_load_val),
      .o_Zero     (tmr_zero)
   );

`ifdef BUTTON_REPEAT_ACCEL_EN
   localparam int unsigned   ACW       = $clog2(ACCEL_COUNT + 1);
   localparam logic [TW-1:0] FAST_LOAD = TW'(sat_load((REPEAT_PERIOD / 4) - 1, TW));

   logic [ACW-1:0] accel_cnt_q, accel_cnt_d, accel_cnt_inc;

   // Repeat reload: the pulse that brings the hold count to ACCEL_COUNT switches to the fast period.
   always_comb begin
      accel_cnt_inc = (accel_cnt_q >= ACW'(ACCEL_COUNT)) ? accel_cnt_q : accel_cnt_q + ACW'(1);
      rep_load_val  = (accel_cnt_inc >= ACW'(ACCEL_COUNT)) ? FAST_LOAD : PERIOD_LOAD;
      accel_cnt_d   = accel_cnt_q;
      if (drop || (state_q == ST_IDLE)) accel_cnt_d = '0;
      else if (fire)                    accel_cnt_d = accel_cnt_inc;
   end

   // Repeat-pulse count for the current hold.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) accel_cnt_q <= '0;
      else       accel_cnt_q <= accel_cnt_d;
   end
`else
   // Fixed repeat period.
   always_comb begin
      rep_load_val = PERIOD_LOAD;
   end
`endif

   // Edge detect and owner/non-owner level selection.
   always_comb begin
      inc_edge  = bus.i_Inc_Level & ~inc_prev_q;
      dec_edge  = bus.i_Dec_Level & ~dec_prev_q;
      owner_lvl = (owner_q == OWN_INC) ? bus.i_Inc_Level : bus.i_Dec_Level;
      other_lvl = (owner_q == OWN_INC) ? bus.i_Dec_Level : bus.i_Inc_Level;
      tmr_en    = ((state_q == ST_DELAY) || (state_q == ST_REPEAT)) && owner_lvl;
   end

   // State register: FSM state, owner, registered pulses, previous switch levels.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_NONE;
         inc_pulse_q <= 1'b0;
         dec_pulse_q <= 1'b0;
         // Held-through-reset switches must be released before they count as a press.
         inc_prev_q  <= 1'b1;
         dec_prev_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         inc_pulse_q <= inc_pulse_d;
         dec_pulse_q <= dec_pulse_d;
         inc_prev_q  <= inc_prev_d;
         dec_prev_q  <= dec_prev_d;
      end
   end

   // Next state: arbitration in IDLE, delay/repeat timing while held, lockout after release.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      inc_pulse_d  = 1'b0;
      dec_pulse_d  = 1'b0;
      inc_prev_d   = bus.i_Inc_Level;
      dec_prev_d   = bus.i_Dec_Level;
      fire         = 1'b0;
      drop         = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = DELAY_LOAD;

      case (state_q)
         ST_IDLE: begin
            if (inc_edge) begin
               owner_d     = OWN_INC;
               inc_pulse_d = 1'b1;
               tmr_load    = 1'b1;
               state_d     = ST_DELAY;
            end else if (dec_edge) begin
               owner_d     = OWN_DEC;
               dec_pulse_d = 1'b1;
               tmr_load    = 1'b1;
               state_d     = ST_DELAY;
            end
         end
         ST_DELAY, ST_REPEAT: begin
            // Release wins over an expiring timer: no pulse after the owner lets go.
            if (!owner_lvl) begin
               drop = 1'b1;
            end else if (tmr_zero) begin
               fire         = 1'b1;
               tmr_load     = 1'b1;
               tmr_load_val = rep_load_val;
               state_d      = ST_REPEAT;
            end
         end
         ST_LOCKOUT: begin
            if (!bus.i_Inc_Level && !bus.i_Dec_Level) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase

      if (fire) begin
         inc_pulse_d = (owner_q == OWN_INC);
         dec_pulse_d = (owner_q == OWN_DEC);
      end

      if (drop) begin
         owner_d = OWN_NONE;
         state_d = other_lvl ? ST_LOCKOUT : ST_IDLE;
      end
   end

   // Outputs: all driven from registers, so reset clears them immediately.
   always_comb begin
      bus.o_Inc_Pulse = inc_pulse_q;
      bus.o_Dec_Pulse = dec_pulse_q;
      bus.o_Owner     = owner_q;
      bus.o_Repeating = (state_q == ST_REPEAT);
   end

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Directed bench for button_repeat_ctrl with REPEAT_DELAY=20, REPEAT_PERIOD=5, ACCEL_COUNT=3.
// Expected pulse cycles are hand-computed; BUTTON_REPEAT_ACCEL_EN selects the accelerated table.
module tb_button_repeat_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   button_repeat_ctrl_if bus();

   button_repeat_ctrl #(
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5),
      .ACCEL_COUNT   (3)
   ) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse log: cycle number of every pulse, sampled on the falling edge.
   int inc_t[$];
   int dec_t[$];
   int both_hi = 0;
   always @(negedge clk) begin
      if (bus.o_Inc_Pulse) inc_t.push_back(cyc);
      if (bus.o_Dec_Pulse) dec_t.push_back(cyc);
      if (bus.o_Inc_Pulse && bus.o_Dec_Pulse) both_hi++;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clr();
      inc_t.delete();
      dec_t.delete();
   endtask

   int c;
   int c2;
   int exp2 [4] = '{1, 21, 26, 31};

   initial begin
      bus.i_Inc_Level = 1'b0;
      bus.i_Dec_Level = 1'b0;
      tick(3);

      // Reset state.
      check("rst_inc_pulse", 32'(bus.o_Inc_Pulse), 0);
      check("rst_dec_pulse", 32'(bus.o_Dec_Pulse), 0);
      check("rst_owner",     32'(bus.o_Owner), 0);
      check("rst_repeating", 32'(bus.o_Repeating), 0);
      rst = 1'b0;
      tick(2);

      // 1: short inc tap -> one pulse one cycle after the edge.
      clr();
      c = cyc;
      bus.i_Inc_Level = 1'b1;
      tick(1);
      check("t1_pulse_now", 32'(bus.o_Inc_Pulse), 1);
      check("t1_owner_inc", 32'(bus.o_Owner), 1);
      tick(9);
      bus.i_Inc_Level = 1'b0;
      tick(3);
      check("t1_owner_none", 32'(bus.o_Owner), 0);
      check("t1_inc_count",  inc_t.size(), 1);
      check("t1_inc_time",   at(inc_t, 0), c + 1);
      check("t1_dec_count",  dec_t.size(), 0);

      // 2: inc held 40 cycles -> delay then repeat.
      clr();
      c = cyc;
      bus.i_Inc_Level = 1'b1;
      tick(20);
      check("t2_not_rep_yet", 32'(bus.o_Repeating), 0);
      tick(1);
      check("t2_repeating", 32'(bus.o_Repeating), 1);
      tick(19);
      bus.i_Inc_Level = 1'b0;
      tick(3);
      check("t2_rep_cleared", 32'(bus.o_Repeating), 0);
      for (int k = 0; k < 4; k++) check("t2_pulse_time", at(inc_t, k), c + exp2[k]);
`ifdef BUTTON_REPEAT_ACCEL_EN
      check("t2_inc_count", inc_t.size(), 13);
      check("t2_pulse4", at(inc_t, 4), c + 32);
`else
      check("t2_inc_count", inc_t.size(), 5);
      check("t2_pulse4", at(inc_t, 4), c + 36);
`endif

      // 3: simultaneous press -> inc wins; dec locked out until re-pressed.
      clr();
      c = cyc;
      bus.i_Inc_Level = 1'b1;
      bus.i_Dec_Level = 1'b1;
      tick(12);
      check("t3_owner_inc", 32'(bus.o_Owner), 1);
      bus.i_Inc_Level = 1'b0;
      tick(2);
      check("t3_owner_none", 32'(bus.o_Owner), 0);
      tick(10);
      check("t3_inc_count", inc_t.size(), 1);
      check("t3_inc_time",  at(inc_t, 0), c + 1);
      check("t3_dec_locked", dec_t.size(), 0);
      bus.i_Dec_Level = 1'b0;
      tick(2);
      clr();
      c = cyc;
      bus.i_Dec_Level = 1'b1;
      tick(1);
      check("t3_dec_owner", 32'(bus.o_Owner), 2);
      tick(4);
      bus.i_Dec_Level = 1'b0;
      tick(2);
      check("t3_dec_count", dec_t.size(), 1);
      check("t3_dec_time",  at(dec_t, 0), c + 1);
      check("t3_no_inc",    inc_t.size(), 0);

      // 4: dec held through reset deassert -> silent until released and re-pressed.
      clr();
      bus.i_Dec_Level = 1'b1;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(30);
      check("t4_held_no_pulse", dec_t.size(), 0);
      check("t4_owner_none",    32'(bus.o_Owner), 0);
      bus.i_Dec_Level = 1'b0;
      tick(2);
      c = cyc;
      bus.i_Dec_Level = 1'b1;
      tick(5);
      bus.i_Dec_Level = 1'b0;
      tick(2);
      check("t4_dec_count", dec_t.size(), 1);
      check("t4_dec_time",  at(dec_t, 0), c + 1);

      // 5: reset during REPEAT clears outputs at once; no pulse after deassert.
      clr();
      c = cyc;
      bus.i_Inc_Level = 1'b1;
      tick(21);
      check("t5_pulse_before", 32'(bus.o_Inc_Pulse), 1);
      check("t5_rep_before",   32'(bus.o_Repeating), 1);
      rst = 1'b1;
      #1;
      check("t5_pulse_async", 32'(bus.o_Inc_Pulse), 0);
      check("t5_owner_async", 32'(bus.o_Owner), 0);
      check("t5_rep_async",   32'(bus.o_Repeating), 0);
      tick(3);
      rst = 1'b0;
      tick(10);
      check("t5_no_post_rst", inc_t.size(), 1);
      bus.i_Inc_Level = 1'b0;
      tick(2);
      c2 = cyc;
      bus.i_Inc_Level = 1'b1;
      tick(3);
      bus.i_Inc_Level = 1'b0;
      tick(2);
      check("t5_idle_count", inc_t.size(), 2);
      check("t5_idle_time",  at(inc_t, 1), c2 + 1);

      // 6: inc held 50 cycles -> repeat spacing with and without acceleration.
      clr();
      c = cyc;
      bus.i_Inc_Level = 1'b1;
      tick(50);
      bus.i_Inc_Level = 1'b0;
      tick(3);
      check("t6_third_rep", at(inc_t, 3), c + 31);
`ifdef BUTTON_REPEAT_ACCEL_EN
      check("t6_inc_count", inc_t.size(), 23);
      check("t6_gap_after", at(inc_t, 4) - at(inc_t, 3), 1);
      check("t6_gap_later", at(inc_t, 5) - at(inc_t, 4), 1);
`else
      check("t6_inc_count", inc_t.size(), 7);
      check("t6_gap_after", at(inc_t, 4) - at(inc_t, 3), 5);
      check("t6_gap_later", at(inc_t, 6) - at(inc_t, 5), 5);
`endif

      check("never_both_pulses", both_hi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
